// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared definitions for the UART command hub.
//   - command byte constants understood by the command FSM
//   - command FSM state type
package uart_cmd_pkg;

  localparam logic [7:0] CMD_TOGGLE_BASE = 8'h31;  // '1' toggles led[0]
  localparam logic [7:0] CMD_TOGGLE_LAST = 8'h38;  // '8' toggles led[7]
  localparam logic [7:0] CMD_CLEAR       = 8'h63;  // 'c'
  localparam logic [7:0] CMD_SET         = 8'h73;  // 's'
  localparam logic [7:0] CMD_STATUS      = 8'h3F;  // '?'

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    WAIT_TX = 2'd2
  } hub_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Searches req starting at last_grant+1 (wrapping) and returns the first set
// index.
//   req        in  N   request vector
//   last_grant in  IW  most recently granted index
//   grant      out IW  selected index (0 when any_req is low)
//   any_req    out 1   at least one request present
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  logic [IW-1:0] idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_grant) + k) % N);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_hub.sv
// uart_cmd_hub: multi-channel UART command hub.
// Buffers one received byte per channel, services channels round-robin,
// applies LED commands and returns one reply byte to the originating channel.
// Optional feature macro: UART_CMD_STATUS_REPLY_EN -- '?' replies with a
// status byte {overrun[chan], 7'b0} | led instead of the echo.
// Ports:
//   clk        in  1          system clock
//   rst        in  1          asynchronous active-high reset
//   rx_valid   in  UARTS      per-channel received-byte strobe
//   rx_data    in  8*UARTS    channel i at [8i+7:8i]
//   tx_busy    in  UARTS      channel transmitter occupied
//   tx_send    out UARTS      one-cycle send strobe
//   tx_data    out 8*UARTS    reply byte, held until next send on that channel
//   led        out NUM_LEDS   LED state
//   heartbeat  out 1          heartbeat counter MSB
//   overrun    out UARTS      sticky byte-dropped flags
//
// state   | meaning
// IDLE    | waiting for a pending byte; grants next channel round-robin
// EXEC    | decodes granted byte, updates led, forms reply
// WAIT_TX | waits for tx_busy[chan] low, then issues tx_send
module uart_cmd_hub
  import uart_cmd_pkg::*;
#(
  parameter int UARTS    = 2,
  parameter int NUM_LEDS = 4,
  parameter int HB_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [UARTS-1:0]     rx_valid,
  input  logic [8*UARTS-1:0]   rx_data,
  input  logic [UARTS-1:0]     tx_busy,
  output logic [UARTS-1:0]     tx_send,
  output logic [8*UARTS-1:0]   tx_data,
  output logic [NUM_LEDS-1:0]  led,
  output logic                 heartbeat,
  output logic [UARTS-1:0]     overrun
);

  localparam int IW = (UARTS > 1) ? $clog2(UARTS) : 1;

  hub_state_t          state, state_n;
  logic [UARTS-1:0]    pend;
  logic [7:0]          hold_q [UARTS];
  logic [7:0]          tx_q   [UARTS];
  logic [IW-1:0]       last_grant, chan, arb_grant;
  logic                arb_any;
  logic [UARTS-1:0]    grant_vec;
  logic [7:0]          cur_byte, reply, reply_n;
  logic [NUM_LEDS-1:0] led_n;
  logic [HB_WIDTH-1:0] hb_cnt;
  logic                grant_en, exec_en, send_en;

  rr_arbiter #(.N(UARTS)) u_arb (
    .req        (pend),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hb_cnt <= '0;
    else     hb_cnt <= hb_cnt + 1'b1;
  end
  assign heartbeat = hb_cnt[HB_WIDTH-1];

  always_comb begin
    grant_vec = '0;
    if (grant_en) grant_vec[arb_grant] = 1'b1;
  end

  // A grant emptying the hold slot in the same cycle frees it for a new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= '0;
      overrun <= '0;
      for (int i = 0; i < UARTS; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < UARTS; i++) begin
        if (rx_valid[i] && (!pend[i] || grant_vec[i])) begin
          hold_q[i] <= rx_data[8*i +: 8];
          pend[i]   <= 1'b1;
        end else begin
          if (rx_valid[i])  overrun[i] <= 1'b1;
          if (grant_vec[i]) pend[i]    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    grant_en = 1'b0;
    exec_en  = 1'b0;
    send_en  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          grant_en = 1'b1;
          state_n  = EXEC;
        end
      end
      EXEC: begin
        exec_en = 1'b1;
        state_n = WAIT_TX;
      end
      WAIT_TX: begin
        if (!tx_busy[chan]) begin
          send_en = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef UART_CMD_STATUS_REPLY_EN
  logic [7:0] led_ext, status_byte;
  always_comb begin
    led_ext                 = '0;
    led_ext[NUM_LEDS-1:0]   = led;
    status_byte             = led_ext | {overrun[chan], 7'b0};
  end
`endif

  always_comb begin
    led_n   = led;
    reply_n = cur_byte;
    if (cur_byte >= CMD_TOGGLE_BASE && cur_byte <= CMD_TOGGLE_LAST) begin
      // Digits beyond NUM_LEDS match no j and fall through with no effect.
      for (int j = 0; j < NUM_LEDS; j++) begin
        if (int'(cur_byte - CMD_TOGGLE_BASE) == j) led_n[j] = ~led[j];
      end
    end else if (cur_byte == CMD_CLEAR) begin
      led_n = '0;
    end else if (cur_byte == CMD_SET) begin
      led_n = '1;
    end
`ifdef UART_CMD_STATUS_REPLY_EN
    else if (cur_byte == CMD_STATUS) begin
      reply_n = status_byte;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan       <= '0;
      cur_byte   <= '0;
      reply      <= '0;
      last_grant <= IW'(UARTS - 1);
      led        <= '0;
      tx_send    <= '0;
      for (int i = 0; i < UARTS; i++) tx_q[i] <= '0;
    end else begin
      tx_send <= '0;
      if (grant_en) begin
        chan       <= arb_grant;
        cur_byte   <= hold_q[arb_grant];
        last_grant <= arb_grant;
      end
      if (exec_en) begin
        led   <= led_n;
        reply <= reply_n;
      end
      if (send_en) begin
        tx_send[chan] <= 1'b1;
        tx_q[chan]    <= reply;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < UARTS; i++) tx_data[8*i +: 8] = tx_q[i];
  end

endmodule

// File: tb/tb_uart_cmd_hub.sv
module tb_uart_cmd_hub;

  localparam int UARTS    = 2;
  localparam int NUM_LEDS = 4;
  localparam int HB_WIDTH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [UARTS-1:0]    rx_valid;
  logic [8*UARTS-1:0]  rx_data;
  logic [UARTS-1:0]    tx_busy;
  logic [UARTS-1:0]    tx_send;
  logic [8*UARTS-1:0]  tx_data;
  logic [NUM_LEDS-1:0] led;
  logic                heartbeat;
  logic [UARTS-1:0]    overrun;

  uart_cmd_hub #(.UARTS(UARTS), .NUM_LEDS(NUM_LEDS), .HB_WIDTH(HB_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_busy   (tx_busy),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .led       (led),
    .heartbeat (heartbeat),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] b;
    logic [7:0] rep;
    logic [3:0] led;
  } vec_t;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_sends = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && (|tx_send)) begin
      n_sends++;
      check("send_onehot", 32'($countones(tx_send)), 32'd1);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_send: tx_send=%b, scoreboard empty", tx_send);
      end else begin
        e = sb.pop_front();
        check("send_chan", 32'(tx_send), 32'(1 << e.ch));
        check("send_data", 32'(tx_data[e.ch*8 +: 8]), 32'(e.data));
      end
    end
  end

  task automatic push_exp(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic strobe(input int ch, input logic [7:0] b);
    @(negedge clk);
    rx_valid[ch]       = 1'b1;
    rx_data[ch*8 +: 8] = b;
    @(negedge clk);
    rx_valid = '0;
  endtask

  // Byte captured at E0; led checked after E1 (unchanged) and E2 (new);
  // tx_send checked after E3.
  task automatic apply_vec(input int ch, input logic [7:0] b, input logic [7:0] rep,
                           input logic [3:0] exp_led);
    logic [3:0] prev;
    prev = led;
    push_exp(ch, rep);
    strobe(ch, b);
    @(negedge clk);
    check("led_before", 32'(led), 32'(prev));
    @(negedge clk);
    check("led_after", 32'(led), 32'(exp_led));
    @(negedge clk);
    check("send_latency", 32'(tx_send), 32'(1 << ch));
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt [10];

  initial begin
    int c;
    int s0;
    vt[0] = '{0, 8'h32, 8'h32, 4'b0010};
    vt[1] = '{1, 8'h73, 8'h73, 4'b1111};
    vt[2] = '{0, 8'h63, 8'h63, 4'b0000};
    vt[3] = '{1, 8'h38, 8'h38, 4'b0000};
    vt[4] = '{0, 8'h31, 8'h31, 4'b0001};
    vt[5] = '{1, 8'h34, 8'h34, 4'b1001};
    vt[6] = '{0, 8'h41, 8'h41, 4'b1001};
    vt[7] = '{1, 8'h33, 8'h33, 4'b1101};
    vt[8] = '{0, 8'h30, 8'h30, 4'b1101};
    vt[9] = '{1, 8'h39, 8'h39, 4'b1101};

    rst      = 1'b1;
    rx_valid = '0;
    rx_data  = '0;
    tx_busy  = '0;
    #12;
    check("rst_led",       32'(led),       32'd0);
    check("rst_tx_send",   32'(tx_send),   32'd0);
    check("rst_tx_data",   32'(tx_data),   32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_heartbeat", 32'(heartbeat), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // heartbeat half period with HB_WIDTH=4 is 8 cycles
    c = 0;
    while (heartbeat !== 1'b1 && c < 40) begin @(negedge clk); c++; end
    c = 0;
    while (heartbeat === 1'b1 && c < 40) begin @(negedge clk); c++; end
    check("hb_half_period", 32'(c), 32'd8);

    for (int i = 0; i < 10; i++) apply_vec(vt[i].ch, vt[i].b, vt[i].rep, vt[i].led);
    check("no_overrun_table", 32'(overrun), 32'd0);

    // simultaneous arrival; last grant on ch1 so ch0 goes first
    apply_vec(1, 8'h63, 8'h63, 4'b0000);
    @(negedge clk);
    rx_valid = 2'b11;
    rx_data  = {8'h34, 8'h31};
    push_exp(0, 8'h31);
    push_exp(1, 8'h34);
    @(negedge clk);
    rx_valid = '0;
    wait_drain(30);
    check("simul_led",     32'(led),     32'b1001);
    check("simul_overrun", 32'(overrun), 32'd0);

    // transmitter busy on ch0: one in WAIT_TX, one buffered, one dropped
    tx_busy = 2'b01;
    s0 = n_sends;
    push_exp(0, 8'h32);
    strobe(0, 8'h32);
    repeat (3) @(negedge clk);
    push_exp(0, 8'h33);
    strobe(0, 8'h33);
    repeat (3) @(negedge clk);
    strobe(0, 8'h34);
    check("busy_overrun", 32'(overrun), 32'b01);
    repeat (40) @(negedge clk);
    check("busy_no_send", 32'(n_sends - s0), 32'd0);
    check("busy_led",     32'(led),          32'b1011);
    tx_busy = '0;
    wait_drain(40);
    repeat (6) @(negedge clk);
    check("busy_two_sends", 32'(n_sends - s0), 32'd2);
    check("busy_led_final", 32'(led),          32'b1111);
    check("overrun_sticky", 32'(overrun),      32'b01);

    // status query
    apply_vec(1, 8'h63, 8'h63, 4'b0000);
    apply_vec(1, 8'h31, 8'h31, 4'b0001);
    apply_vec(1, 8'h33, 8'h33, 4'b0101);
`ifdef UART_CMD_STATUS_REPLY_EN
    apply_vec(1, 8'h3F, 8'h05, 4'b0101);
    apply_vec(0, 8'h3F, 8'h85, 4'b0101);
`else
    apply_vec(1, 8'h3F, 8'h3F, 4'b0101);
    apply_vec(0, 8'h3F, 8'h3F, 4'b0101);
`endif

    // reset while tx_send is high
    push_exp(0, 8'h32);
    strobe(0, 8'h32);
    repeat (3) @(negedge clk);
    check("pre_rst_send", 32'(tx_send), 32'b01);
    #1 rst = 1'b1;
    #1;
    check("rst_async_send",    32'(tx_send),   32'd0);
    check("rst_async_led",     32'(led),       32'd0);
    check("rst_async_overrun", 32'(overrun),   32'd0);
    check("rst_async_hb",      32'(heartbeat), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // reset while in WAIT_TX with a pending byte and an overrun
    tx_busy = 2'b10;
    strobe(1, 8'h73);
    repeat (3) @(negedge clk);
    strobe(0, 8'h31);
    @(negedge clk);
    strobe(0, 8'h32);
    check("wait_pre_led",     32'(led),      32'b1111);
    check("wait_pre_overrun", 32'(overrun),  32'b01);
    #2 rst = 1'b1;
    #1;
    check("rst_wait_led",     32'(led),      32'd0);
    check("rst_wait_overrun", 32'(overrun),  32'd0);
    check("rst_wait_send",    32'(tx_send),  32'd0);
    check("rst_wait_pend",    32'(dut.pend), 32'd0);
    sb.delete();
    s0 = n_sends;
    @(negedge clk);
    rst     = 1'b0;
    tx_busy = '0;
    repeat (20) @(negedge clk);
    check("rst_lost_pending", 32'(n_sends - s0), 32'd0);

    apply_vec(0, 8'h73, 8'h73, 4'b1111);
    wait_drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
